// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the two-port RAM arbiter.
// Grant statistics are enabled by defining RAM_ARB_STATS_EN.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 6;
  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned STATS_W        = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // Saturating increment for the grant counters
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, pointer records
// the most recently granted port.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt_c,
  output logic b_gnt_c
);

  port_id_t last_q;
  port_id_t last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

  // On conflict the port that did not win last time gets the grant
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    last_d  = last_q;
    if (!rst) begin
      if (a_req && (!b_req || last_q == PORT_B)) begin
        a_gnt_c = 1'b1;
      end else if (b_req) begin
        b_gnt_c = 1'b1;
      end
    end
    if (a_gnt_c) begin
      last_d = PORT_A;
    end else if (b_gnt_c) begin
      last_d = PORT_B;
    end
  end

endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read: data for the address presented on
// one edge is available after that edge. Writes land on the same edge.
module single_port_ram #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              write_enable,
  output logic [DATA_W-1:0] read
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[addr] <= data;
    end
    read <= mem[addr];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with round-robin grant,
// address/data mux and a one-cycle read-return pipeline per port.
// Optional per-port grant counters are added when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_write_enable,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic              b_write_enable,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_read,
  output logic [DATA_W-1:0] b_read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write_enable,
`ifdef RAM_ARB_STATS_EN
  output logic [STATS_W-1:0] a_grant_count,
  output logic [STATS_W-1:0] b_grant_count,
`endif
  input  logic [DATA_W-1:0] ram_read
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              a_pend_q;
  logic              b_pend_q;
  logic [DATA_W-1:0] a_hold_q;
  logic [DATA_W-1:0] b_hold_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .b_req   (b_req),
    .a_gnt_c (a_gnt),
    .b_gnt_c (b_gnt)
  );

  // RAM side follows the granted port, otherwise holds the last access
  always_comb begin
    ram_addr         = addr_q;
    ram_data         = data_q;
    ram_write_enable = 1'b0;
    if (a_gnt) begin
      ram_addr         = a_addr;
      ram_data         = a_data;
      ram_write_enable = a_write_enable;
    end else if (b_gnt) begin
      ram_addr         = b_addr;
      ram_data         = b_data;
      ram_write_enable = b_write_enable;
    end
  end

  // A read pending across a reset edge is dropped
  assign a_rvalid = a_pend_q & ~rst;
  assign b_rvalid = b_pend_q & ~rst;
  assign a_read   = a_rvalid ? ram_read : a_hold_q;
  assign b_read   = b_rvalid ? ram_read : b_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (a_gnt || b_gnt) begin
        addr_q <= ram_addr;
        data_q <= ram_data;
      end
      a_pend_q <= a_gnt & ~a_write_enable;
      b_pend_q <= b_gnt & ~b_write_enable;
      a_hold_q <= a_read;
      b_hold_q <= b_read;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [STATS_W-1:0] a_cnt_q;
  logic [STATS_W-1:0] b_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_gnt) a_cnt_q <= sat_inc(a_cnt_q);
      if (b_gnt) b_cnt_q <= sat_inc(b_cnt_q);
    end
  end

  assign a_grant_count = a_cnt_q;
  assign b_grant_count = b_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter driving a single_port_ram; vector table plus
// hand-written reset and statistics sequences, read data via scoreboard.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_write_enable = 1'b0;
  logic          b_req = 1'b0, b_write_enable = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_read, b_read;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_read;
  logic          ram_write_enable;
`ifdef RAM_ARB_STATS_EN
  logic [STATS_W-1:0] a_grant_count, b_grant_count;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_req            (a_req),
    .a_write_enable   (a_write_enable),
    .a_addr           (a_addr),
    .a_data           (a_data),
    .b_req            (b_req),
    .b_write_enable   (b_write_enable),
    .b_addr           (b_addr),
    .b_data           (b_data),
    .a_gnt            (a_gnt),
    .b_gnt            (b_gnt),
    .a_rvalid         (a_rvalid),
    .b_rvalid         (b_rvalid),
    .a_read           (a_read),
    .b_read           (b_read),
    .ram_addr         (ram_addr),
    .ram_data         (ram_data),
    .ram_write_enable (ram_write_enable),
`ifdef RAM_ARB_STATS_EN
    .a_grant_count    (a_grant_count),
    .b_grant_count    (b_grant_count),
`endif
    .ram_read         (ram_read)
  );

  single_port_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk          (clk),
    .addr         (ram_addr),
    .data         (ram_data),
    .write_enable (ram_write_enable),
    .read         (ram_read)
  );

  typedef struct {
    logic          ar;
    logic          awe;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          br;
    logic          bwe;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          eag;
    logic          ebg;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] qa[$], qb[$];
  bit            exp_rv_a, exp_rv_b, ram_known;
  logic [DW-1:0] last_a, last_b, exp_data;
  logic [AW-1:0] exp_addr;
  int            cnt_a, cnt_b;
  int            n_checks = 0;
  int            n_err = 0;

  function automatic vec_t mk(input logic ar, input logic awe, input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad, input logic br, input logic bwe,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic eag, input logic ebg);
    vec_t v;
    v.ar = ar; v.awe = awe; v.aa = aa; v.ad = ad;
    v.br = br; v.bwe = bwe; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive, compare against expectations, then advance the model
  task automatic apply(input vec_t v, input string nm);
    logic we;
    @(negedge clk);
    a_req = v.ar; a_write_enable = v.awe; a_addr = v.aa; a_data = v.ad;
    b_req = v.br; b_write_enable = v.bwe; b_addr = v.ba; b_data = v.bd;
    #1;
    chk({nm, " a_rvalid"}, 32'(a_rvalid), 32'(exp_rv_a));
    chk({nm, " b_rvalid"}, 32'(b_rvalid), 32'(exp_rv_b));
    if (exp_rv_a && qa.size() > 0) last_a = qa.pop_front();
    if (exp_rv_b && qb.size() > 0) last_b = qb.pop_front();
    chk({nm, " a_read"}, 32'(a_read), 32'(last_a));
    chk({nm, " b_read"}, 32'(b_read), 32'(last_b));
    chk({nm, " a_gnt"}, 32'(a_gnt), 32'(v.eag));
    chk({nm, " b_gnt"}, 32'(b_gnt), 32'(v.ebg));
    we = (v.eag & v.awe) | (v.ebg & v.bwe);
    chk({nm, " ram_we"}, 32'(ram_write_enable), 32'(we));
    if (v.eag) begin
      exp_addr = v.aa; exp_data = v.ad; ram_known = 1'b1;
    end else if (v.ebg) begin
      exp_addr = v.ba; exp_data = v.bd; ram_known = 1'b1;
    end
    if (ram_known) begin
      chk({nm, " ram_addr"}, 32'(ram_addr), 32'(exp_addr));
      chk({nm, " ram_data"}, 32'(ram_data), 32'(exp_data));
    end
    exp_rv_a = v.eag & ~v.awe;
    exp_rv_b = v.ebg & ~v.bwe;
    if (exp_rv_a) qa.push_back(ref_mem[v.aa]);
    if (exp_rv_b) qb.push_back(ref_mem[v.ba]);
    if (v.eag && v.awe) ref_mem[v.aa] = v.ad;
    if (v.ebg && v.bwe) ref_mem[v.ba] = v.bd;
    if (v.eag && cnt_a < 65535) cnt_a++;
    if (v.ebg && cnt_b < 65535) cnt_b++;
  endtask

  // Two reset cycles with write requests pending; grants must stay low
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_req = 1'b1; a_write_enable = 1'b1;
    b_req = 1'b1; b_write_enable = 1'b1;
    #1;
    chk("rst a_gnt", 32'(a_gnt), 32'd0);
    chk("rst b_gnt", 32'(b_gnt), 32'd0);
    chk("rst ram_we", 32'(ram_write_enable), 32'd0);
    chk("rst a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst b_rvalid", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("rst2 a_gnt", 32'(a_gnt), 32'd0);
    chk("rst2 a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst2 a_read", 32'(a_read), 32'd0);
    chk("rst2 b_read", 32'(b_read), 32'd0);
    rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    qa.delete(); qb.delete();
    exp_rv_a = 1'b0; exp_rv_b = 1'b0;
    last_a = '0; last_b = '0;
    ram_known = 1'b0;
    cnt_a = 0; cnt_b = 0;
  endtask

  initial begin
    do_reset();

    vecs.push_back(mk(1, 1, 6'h01, 8'h33, 0, 0, 6'h00, 8'h00, 1, 0)); // A alone write
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0)); // idle, no rvalid
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 1, 0, 6'h01, 8'h00, 0, 1)); // B reads 01
    vecs.push_back(mk(1, 1, 6'h02, 8'hAA, 1, 1, 6'h02, 8'h55, 1, 0)); // conflict, A wins
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 1, 1, 6'h02, 8'h55, 0, 1)); // B next
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 1, 0, 6'h02, 8'h00, 0, 1)); // B reads 02 -> 55
    for (int i = 0; i < 4; i++)                                        // alternating reads
      vecs.push_back(mk(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, (i % 2 == 0), (i % 2 == 1)));
    vecs.push_back(mk(1, 1, 6'h05, 8'h77, 0, 0, 6'h00, 8'h00, 1, 0)); // A writes 77
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 1, 0, 6'h05, 8'h00, 0, 1)); // B reads it next
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 6'h3F, 8'hFF, 0, 0, 6'h00, 8'h00, 1, 0)); // top address
    vecs.push_back(mk(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 6'h01, 8'h00, 1, 1, 6'h00, 8'h00, 0, 1)); // conflict, B wins
    vecs.push_back(mk(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 1, 0, 6'h00, 8'h00, 0, 1)); // B reads 00 -> 00
    vecs.push_back(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Read granted immediately before reset must not return data
    apply(mk(1, 0, 6'h05, 8'h00, 0, 0, 6'h00, 8'h00, 1, 0), "pre_rst_read");
    do_reset();
    apply(mk(1, 1, 6'h10, 8'h12, 1, 1, 6'h11, 8'h34, 1, 0), "post_rst_conflict");
    apply(mk(0, 0, 6'h00, 8'h00, 1, 1, 6'h11, 8'h34, 0, 1), "post_rst_b");
    apply(mk(1, 0, 6'h10, 8'h00, 1, 0, 6'h11, 8'h00, 1, 0), "post_rst_rd_a");
    apply(mk(1, 0, 6'h10, 8'h00, 1, 0, 6'h11, 8'h00, 0, 1), "post_rst_rd_b");
    apply(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0), "post_rst_idle0");
    apply(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0), "post_rst_idle1");

`ifdef RAM_ARB_STATS_EN
    do_reset();
    chk("cnt_a reset", 32'(a_grant_count), 32'd0);
    chk("cnt_b reset", 32'(b_grant_count), 32'd0);
    for (int i = 0; i < 4; i++)
      apply(mk(1, 1, 6'h20, 8'h01, 1, 1, 6'h21, 8'h02, (i % 2 == 0), (i % 2 == 1)),
            $sformatf("stats%0d", i));
    apply(mk(1, 1, 6'h20, 8'h01, 0, 0, 6'h00, 8'h00, 1, 0), "stats4");
    apply(mk(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0), "stats_idle");
    chk("cnt_a 3", 32'(a_grant_count), 32'd3);
    chk("cnt_b 2", 32'(b_grant_count), 32'd2);
    @(negedge clk);
    a_req = 1'b1; a_write_enable = 1'b1; b_req = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    chk("cnt_a sat", 32'(a_grant_count), 32'hFFFF);
    chk("cnt_b hold", 32'(b_grant_count), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
